// File: rtl/muldiv_pkg.sv
// Shared types and constants for the MUL/DIV sequencer.
package muldiv_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_MUL_IT,
    ST_DIV_ABSA,
    ST_DIV_ABSB,
    ST_DIV_IT,
    ST_DIV_RST,
    ST_DIV_SGNQ,
    ST_DIV_SGNR,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    AOP_PASS,
    AOP_ADD,
    AOP_SUB
  } aop_e;

  localparam logic        OP_MUL  = 1'b0;
  localparam logic        OP_DIV  = 1'b1;
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;
  localparam int          ITERS   = 32;

endpackage

// File: rtl/muldiv_opsel.sv
// Adder operand select: maps the sequencer state onto a pass, add or subtract
// of 33-bit operands; bit 32 of each operand is returned so the caller can extend the sum.
module muldiv_opsel
  import muldiv_pkg::*;
(
  input  state_e      state_i,
  input  logic [32:0] a_i,
  input  logic [31:0] q_i,
  input  logic        q_1_i,
  input  logic [32:0] m_i,
  input  logic        neg_q_i,
  input  logic        neg_r_i,
  output logic [31:0] add_a_o,
  output logic [31:0] add_b_o,
  output logic        add_cin_o,
  output logic        a_x_o,
  output logic        b_x_o
);

  logic [32:0] opnd_a;
  logic [32:0] opnd_b;
  aop_e        aop;

  always_comb begin
    opnd_a = '0;
    opnd_b = '0;
    aop    = AOP_PASS;
    case (state_i)
      ST_MUL_IT: begin
        opnd_a = a_i;
        opnd_b = m_i;
        case ({q_i[0], q_1_i})
          2'b10:   aop = AOP_SUB;
          2'b01:   aop = AOP_ADD;
          default: aop = AOP_PASS;
        endcase
      end
      ST_DIV_ABSA: begin
        if (q_i[31]) begin
          opnd_b = {q_i[31], q_i};
          aop    = AOP_SUB;
        end else begin
          opnd_a = {1'b0, q_i};
        end
      end
      ST_DIV_ABSB: begin
        if (m_i[32]) begin
          opnd_b = m_i;
          aop    = AOP_SUB;
        end else begin
          opnd_a = m_i;
        end
      end
      ST_DIV_IT: begin
        // Shift-left of {A,Q} is folded into operand A.
        opnd_a = {a_i[31:0], q_i[31]};
        opnd_b = m_i;
        aop    = a_i[32] ? AOP_ADD : AOP_SUB;
      end
      ST_DIV_RST: begin
        opnd_a = a_i;
        opnd_b = m_i;
        aop    = a_i[32] ? AOP_ADD : AOP_PASS;
      end
      ST_DIV_SGNQ: begin
        if (neg_q_i) begin
          opnd_b = {1'b0, q_i};
          aop    = AOP_SUB;
        end else begin
          opnd_a = {1'b0, q_i};
        end
      end
      ST_DIV_SGNR: begin
        if (neg_r_i) begin
          opnd_b = a_i;
          aop    = AOP_SUB;
        end else begin
          opnd_a = a_i;
        end
      end
      default: begin
        opnd_a = '0;
        opnd_b = '0;
        aop    = AOP_PASS;
      end
    endcase
  end

  always_comb begin
    add_a_o   = opnd_a[31:0];
    a_x_o     = opnd_a[32];
    add_b_o   = '0;
    b_x_o     = 1'b0;
    add_cin_o = 1'b0;
    case (aop)
      AOP_ADD: begin
        add_b_o = opnd_b[31:0];
        b_x_o   = opnd_b[32];
      end
      AOP_SUB: begin
        add_b_o   = ~opnd_b[31:0];
        b_x_o     = ~opnd_b[32];
        add_cin_o = 1'b1;
      end
      default: begin
        add_b_o   = '0;
        b_x_o     = 1'b0;
        add_cin_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MUL (radix-2 Booth) / signed DIV (non-restoring) sequencer that
// borrows an external 32-bit adder; results land in hi/lo.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [32:0]        a_q, a_d;
  logic [31:0]        q_q, q_d;
  logic               q1_q, q1_d;
  logic [32:0]        m_q, m_d;
  logic               nega_q, nega_d;
  logic               negb_q, negb_d;
  logic               dbz_q, dbz_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic               a_x, b_x;
  logic [32:0]        res;
  logic               last_it;

  muldiv_opsel u_opsel (
    .state_i   (state_q),
    .a_i       (a_q),
    .q_i       (q_q),
    .q_1_i     (q1_q),
    .m_i       (m_q),
    .neg_q_i   (nega_q ^ negb_q),
    .neg_r_i   (nega_q),
    .add_a_o   (add_a),
    .add_b_o   (add_b),
    .add_cin_o (add_cin),
    .a_x_o     (a_x),
    .b_x_o     (b_x)
  );

  // 33-bit result: the 32-bit adder plus a sign-extension bit.
  assign res     = {a_x ^ b_x ^ add_cout, add_sum};
  assign last_it = (cnt_q == CNT_W'(ITERS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    nega_d  = nega_q;
    negb_d  = negb_q;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d  = '0;
          a_d    = '0;
          q_d    = opa;
          q1_d   = 1'b0;
          m_d    = {opb[31], opb};
          nega_d = opa[31];
          negb_d = opb[31];
          dbz_d  = 1'b0;
          if (op == OP_MUL) begin
            state_d = ST_MUL_IT;
          end else if (opb == '0) begin
            state_d = ST_DONE;
            dbz_d   = 1'b1;
            hi_d    = opa;
            lo_d    = DIV0_LO;
          end else begin
            state_d = ST_DIV_ABSA;
          end
        end
      end
      ST_MUL_IT: begin
        a_d   = {res[32], res[32:1]};
        q_d   = {res[0], q_q[31:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q + CNT_W'(1);
        if (last_it) begin
          state_d = ST_DONE;
          hi_d    = res[32:1];
          lo_d    = {res[0], q_q[31:1]};
        end
      end
      ST_DIV_ABSA: begin
        q_d     = res[31:0];
        state_d = ST_DIV_ABSB;
      end
      ST_DIV_ABSB: begin
        m_d     = res;
        state_d = ST_DIV_IT;
      end
      ST_DIV_IT: begin
        a_d   = res;
        q_d   = {q_q[30:0], ~res[32]};
        cnt_d = cnt_q + CNT_W'(1);
        if (last_it) begin
          state_d = ST_DIV_RST;
        end
      end
      ST_DIV_RST: begin
        a_d     = res;
        state_d = ST_DIV_SGNQ;
      end
      ST_DIV_SGNQ: begin
        q_d     = res[31:0];
        state_d = ST_DIV_SGNR;
      end
      ST_DIV_SGNR: begin
        a_d     = res;
        state_d = ST_DONE;
        hi_d    = res[31:0];
        lo_d    = q_q;
      end
      ST_DONE: begin
        dbz_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      nega_q  <= 1'b0;
      negb_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      nega_q  <= nega_d;
      negb_q  <= negb_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign div_by_zero = done & dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected results, a
// negedge monitor pops and compares on every done pulse.
module tb_muldiv_seq;

  logic        clk;
  logic        clear;
  logic        start;
  logic        op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  muldiv_seq dut (
    .clk         (clk),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .opa         (opa),
    .opb         (opb),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_cin     (add_cin),
    .add_sum     (add_sum),
    .add_cout    (add_cout)
  );

  // Shared 32-bit adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!clear) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending transaction (hi=%h lo=%h)", hi, lo);
        end else begin
          e = sb.pop_front();
          $display("txn done cyc=%0d hi=%h lo=%h dbz=%0b (exp cyc=%0d hi=%h lo=%h dbz=%0b)",
                   cyc, hi, lo, div_by_zero, e.cyc, e.hi, e.lo, e.dbz);
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
          chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        chk("dbz_outside_done", {31'd0, div_by_zero}, 32'd0);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the first idle negedge after done.
  task automatic do_op(input logic opv, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                       input int lat);
    exp_t e;
    int   n;
    start = 1'b1;
    op    = opv;
    opa   = a;
    opb   = b;
    e.hi  = ehi;
    e.lo  = elo;
    e.dbz = edbz;
    e.cyc = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(n), 32'(lat));
    chk("hi_hold", hi, ehi);
    chk("lo_hold", lo, elo);
    chk("idle_add_a", add_a, 32'd0);
    chk("idle_add_b", add_b, 32'd0);
    chk("idle_add_cin", {31'd0, add_cin}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    opa   = '0;
    opb   = '0;
    #2 clear = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_add_a", add_a, 32'd0);
    chk("rst_add_b", add_b, 32'd0);
    chk("rst_add_cin", {31'd0, add_cin}, 32'd0);
    clear = 1'b0;
    @(negedge clk);

    // MUL vectors (latency 33)
    do_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33);
    do_op(1'b0, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b0, 33);
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 33);
    // DIV vectors (latency 38)
    do_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 38);
    do_op(1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 38);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 38);
    do_op(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 38);
    // Divide by zero (latency 1)
    do_op(1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0 | 1'b1, 1);

    // Abort: start MUL, ignored start while busy, then clear mid-operation
    start = 1'b1;
    op    = 1'b0;
    opa   = 32'h0000_1234;
    opb   = 32'h0000_0055;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    opa   = 32'h0000_0009;
    opb   = 32'h0000_0000;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_ignored_start", {31'd0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    clear = 1'b1;
    #1;
    chk("clear_busy", {31'd0, busy}, 32'd0);
    chk("clear_done", {31'd0, done}, 32'd0);
    chk("clear_hi", hi, 32'd0);
    chk("clear_lo", lo, 32'd0);
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    $display("txn aborted MUL cleared");

    do_op(1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C, 1'b0, 33);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
